// File: rtl/reset_sequencer_pkg.sv
// Shared types, defaults and sizing helpers for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_SYNC_DEPTH  = 2;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_GAP_CYCLES  = 4;

    // One spare bit above the larger of the two terminal counts.
    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(max_cycles) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Reset synchronizer: asserts asynchronously, releases DEPTH clk edges after reset drops.
module reset_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_sync_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift zeros in once reset is gone; any reset pulse refills the chain with ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], 1'b0};
        end
    end

    assign rst_sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: hold, then release stages 0..N-1 one gap apart.
// Optional macro RESET_SEQUENCER_ACK_EN gates each advance on a per-stage ack.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int SYNC_DEPTH  = DEF_SYNC_DEPTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_rst_req_i,
`ifdef RESET_SEQUENCER_ACK_EN
    input  logic [NUM_STAGES-1:0] stage_ack_i,
`endif
    output logic [NUM_STAGES-1:0] stage_rst_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IW = $clog2(NUM_STAGES) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    logic                  rst_sync_s;
    logic                  ack_sel_s;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    reset_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_reset_sync (
        .clk        (clk),
        .reset      (reset),
        .rst_sync_o (rst_sync_s)
    );

`ifdef RESET_SEQUENCER_ACK_EN
    logic [NUM_STAGES-1:0] idx_hit_s;

    // Pick the ack belonging to the stage currently waiting on its gap.
    always_comb begin
        idx_hit_s = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            idx_hit_s[k] = (idx_q == IW'(k));
        end
        ack_sel_s = |(stage_ack_i & idx_hit_s);
    end
`else
    assign ack_sel_s = 1'b1;
`endif

    // Next-state logic; stage releases shift a zero in at the bottom so the
    // outputs stay a thermometer code by construction.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d     = RELEASE;
                    stage_rst_d = stage_rst_q << 1'b1;
                    idx_d       = '0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    if (ack_sel_s) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            idx_d       = idx_q + 1'b1;
                            stage_rst_d = stage_rst_q << 1'b1;
                            cnt_d       = '0;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (sw_rst_req_i) begin
                    state_d     = HOLD;
                    cnt_d       = '0;
                    idx_d       = '0;
                    stage_rst_d = '1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d     = HOLD;
                cnt_d       = '0;
                idx_d       = '0;
                stage_rst_d = '1;
                busy_d      = 1'b1;
                done_d      = 1'b0;
            end
        endcase
    end

    // State and output registers, forced to the held state by the synchronized reset.
    always_ff @(posedge clk or posedge rst_sync_s) begin
        if (rst_sync_s) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_q <= '1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign stage_rst_o = stage_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (NUM_STAGES=3, SYNC_DEPTH=2, HOLD=4, GAP=2).
module tb_reset_sequencer;

    localparam int N  = 3;
    localparam int SD = 2;
    localparam int H  = 4;
    localparam int G  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         sw_rst_req_i;
    logic [N-1:0] stage_rst_o;
    logic         busy_o;
    logic         done_o;
`ifdef RESET_SEQUENCER_ACK_EN
    logic [N-1:0] stage_ack_i;
`endif

    reset_sequencer #(
        .NUM_STAGES  (N),
        .SYNC_DEPTH  (SD),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_rst_req_i (sw_rst_req_i),
`ifdef RESET_SEQUENCER_ACK_EN
        .stage_ack_i  (stage_ack_i),
`endif
        .stage_rst_o  (stage_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a sequence started at edge t0 releases stage k at
    // t0+H+k*G and completes at t0+H+N*G; no sequence is active while in reset.
    int ecount = 0;
    int t0 = 0;
    bit seq_valid = 1'b0;

    typedef struct packed {
        logic         sw;
        logic [N-1:0] stage;
        logic         done;
        logic         busy;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [N-1:0] model_stage();
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s[k] = !(seq_valid && (ecount >= t0 + H + k * G));
        end
        return s;
    endfunction

    function automatic logic model_done();
        return seq_valid && (ecount >= t0 + H + N * G);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    task automatic chk_invariants();
        logic thermo_ok;
        thermo_ok = 1'b1;
        for (int k = 1; k < N; k++) begin
            if (stage_rst_o[k] == 1'b0 && stage_rst_o[k-1] == 1'b1) thermo_ok = 1'b0;
        end
        chk("thermometer", 32'(thermo_ok), 32'd1);
        chk("done_vs_busy", 32'(done_o), 32'(!busy_o));
    endtask

    task automatic chk_model();
        chk("model_stage", 32'(stage_rst_o), 32'(model_stage()));
        chk("model_done", 32'(done_o), 32'(model_done()));
        chk("model_busy", 32'(busy_o), 32'(!model_done()));
        chk_invariants();
    endtask

    task automatic edge_step();
        @(posedge clk);
        ecount++;
        if (!reset && seq_valid && sw_rst_req_i && (ecount > t0 + H + N * G)) t0 = ecount;
        #1;
    endtask

    task automatic reset_assert();
        reset     = 1'b1;
        seq_valid = 1'b0;
        #1;
        chk("async_rst_stage", 32'(stage_rst_o), 32'(3'b111));
        chk("async_rst_done", 32'(done_o), 32'd0);
        chk("async_rst_busy", 32'(busy_o), 32'd1);
    endtask

    task automatic reset_release();
        reset     = 1'b0;
        seq_valid = 1'b1;
        t0        = ecount + SD;
    endtask

    initial begin
        int base;
        reset        = 1'b1;
        sw_rst_req_i = 1'b0;
`ifdef RESET_SEQUENCER_ACK_EN
        stage_ack_i  = '1;
`endif
        #2;
        chk("por_stage", 32'(stage_rst_o), 32'(3'b111));
        chk("por_done", 32'(done_o), 32'd0);
        chk("por_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 3; i++) edge_step();

        // Power-on sequence with sw pulses during HOLD/RELEASE that must be ignored.
        tbl[0]  = '{1'b0, 3'b111, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 3'b111, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 3'b111, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 3'b111, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 3'b111, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 3'b110, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 3'b110, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 3'b100, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 3'b100, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 3'b000, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 3'b000, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 3'b000, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 3'b000, 1'b1, 1'b0};
        reset_release();
        for (int i = 0; i < 13; i++) begin
            sw_rst_req_i = tbl[i].sw;
            edge_step();
            chk($sformatf("tbl_stage_e%0d", i + 1), 32'(stage_rst_o), 32'(tbl[i].stage));
            chk($sformatf("tbl_done_e%0d", i + 1), 32'(done_o), 32'(tbl[i].done));
            chk($sformatf("tbl_busy_e%0d", i + 1), 32'(busy_o), 32'(tbl[i].busy));
            chk_invariants();
        end
        sw_rst_req_i = 1'b0;

        // Software pulse in RUN: stages release at T+4/T+6/T+8, done at T+10.
        edge_step();
        sw_rst_req_i = 1'b1;
        edge_step();
        sw_rst_req_i = 1'b0;
        base = ecount;
        chk("sw_stage_T", 32'(stage_rst_o), 32'(3'b111));
        chk("sw_done_T", 32'(done_o), 32'd0);
        for (int i = 1; i <= 11; i++) begin
            edge_step();
            chk_model();
            if (ecount - base == 4) chk("sw_stage_T4", 32'(stage_rst_o), 32'(3'b110));
            if (ecount - base == 6) chk("sw_stage_T6", 32'(stage_rst_o), 32'(3'b100));
            if (ecount - base == 9) chk("sw_done_T9", 32'(done_o), 32'd0);
            if (ecount - base == 10) chk("sw_done_T10", 32'(done_o), 32'd1);
        end

        // Async reset between edges 8 and 9, then the full power-on timing again.
        reset_assert();
        edge_step();
        chk_model();
        reset_release();
        for (int i = 0; i < 8; i++) begin
            edge_step();
            chk_model();
        end
        chk("mid_rel_stage_e8", 32'(stage_rst_o), 32'(3'b100));
        reset_assert();
        edge_step();
        edge_step();
        chk_model();
        reset_release();
        base = ecount;
        for (int i = 0; i < 13; i++) begin
            edge_step();
            chk_model();
            if (ecount - base == 5) chk("rerun_stage_e5", 32'(stage_rst_o), 32'(3'b111));
            if (ecount - base == 6) chk("rerun_stage_e6", 32'(stage_rst_o), 32'(3'b110));
            if (ecount - base == 11) chk("rerun_done_e11", 32'(done_o), 32'd0);
            if (ecount - base == 12) chk("rerun_done_e12", 32'(done_o), 32'd1);
        end

        // Randomized requests and occasional async resets against the model.
        for (int i = 0; i < 600; i++) begin
            sw_rst_req_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 79) == 0) begin
                reset_assert();
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                    edge_step();
                    chk_model();
                end
                reset_release();
            end
            edge_step();
            chk_model();
        end
        sw_rst_req_i = 1'b0;

`ifdef RESET_SEQUENCER_ACK_EN
        // Ack for stage 1 arrives 5 cycles late: stage 2 at edge 15, done at 17.
        reset_assert();
        edge_step();
        stage_ack_i = 3'b101;
        reset_release();
        base = ecount;
        for (int i = 1; i <= 18; i++) begin
            edge_step();
            chk("ack_stage", 32'(stage_rst_o),
                32'({(i < 15), (i < 8), (i < 6)}));
            chk("ack_done", 32'(done_o), 32'(i >= 17));
            chk_invariants();
            if (i == 14) stage_ack_i = 3'b111;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generates staged, synchronously-released reset outputs for a chain of downstream register banks (non-resettable, sync-reset and async-reset flop groups).
- Global `reset` asserts every stage immediately. Release is synchronized to `clk`, held for a fixed time, then each stage is released in order, with a fixed gap between stages.
- Also provides a software-requested re-sequencing path once the system is running. Sits at the top of each clock domain, between the board/system reset and the datapath.

Parameters:
- NUM_STAGES, 4: number of reset outputs, released in index order 0..NUM_STAGES-1; ≥1.
- SYNC_DEPTH, 2: flops in the reset-deassertion synchronizer; ≥2.
- HOLD_CYCLES, 8: clk cycles all stages are held after synchronized release or a sw request; ≥1.
- GAP_CYCLES, 4: clk cycles between consecutive stage releases, and after the last release before done; ≥1.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset; clock clk.
- sw_rst_req_i  input  1  software re-sequence request; sampled only in RUN.
- stage_rst_o  output  NUM_STAGES  per-stage active-high reset, registered.
- busy_o  output  1  high whenever the FSM is not in RUN.
- done_o  output  1  high in RUN (all stages released).

Behaviour:
- Reset assertion:
  - `reset` high asynchronously forces, with no clock needed: `stage_rst_o` = all 1s, `busy_o` = 1, `done_o` = 0, FSM = HOLD, counters = 0, stage index = 0.
  - Applies at any time, including mid-sequence or in RUN.
- Synchronizer: `reset` passes through SYNC_DEPTH flops (async set, sync clear). The internal `rst_sync` falls on edge SYNC_DEPTH after `reset` deasserts (edge 1 = first rising edge after deassertion).
- FSM states: HOLD, RELEASE, RUN. All FSM logic, counters and outputs are async-reset by `rst_sync`.
- HOLD:
  - Counter counts 0..HOLD_CYCLES-1.
  - On the edge where count = HOLD_CYCLES-1: go to RELEASE, set `stage_rst_o[0]` <= 0, index <= 0, counter <= 0.
- RELEASE:
  - Counter counts 0..GAP_CYCLES-1.
  - At GAP_CYCLES-1 with index < NUM_STAGES-1: index++, `stage_rst_o[index+1]` <= 0, counter <= 0.
  - At GAP_CYCLES-1 with index = NUM_STAGES-1: go to RUN, `done_o` <= 1, `busy_o` <= 0.
- RUN:
  - Outputs hold.
  - If `sw_rst_req_i` = 1 at an edge: `stage_rst_o` <= all 1s, `done_o` <= 0, `busy_o` <= 1, go to HOLD with counter 0.
- Power-on timing:
  - `stage_rst_o[k]` falls on edge SYNC_DEPTH + HOLD_CYCLES + k*GAP_CYCLES.
  - `done_o` rises on edge SYNC_DEPTH + HOLD_CYCLES + NUM_STAGES*GAP_CYCLES.
- Software-request timing: for a request sampled at edge T, `stage_rst_o[k]` falls on edge T + HOLD_CYCLES + k*GAP_CYCLES.
- Ignored requests: `sw_rst_req_i` in HOLD or RELEASE is ignored. It is not queued and does not restart the sequence.
- Held request: a request held high continuously re-enters HOLD on the first RUN cycle, so the sequence loops. This is legal; software must pulse the request.
- Monotonic release: once a stage is released, only `reset` or a sw request re-asserts it. The bits of `stage_rst_o` form a thermometer code at all times: bit k released implies all lower bits released.
- Counter widths: $clog2 of max(HOLD_CYCLES, GAP_CYCLES) + 1. Index width: $clog2(NUM_STAGES) + 1. No wrap is reachable.

Optional Feature:
- Macro: RESET_SEQUENCER_ACK_EN.
- Defined:
  - Adds input port `stage_ack_i`, width NUM_STAGES, meaning "stage k is out of reset and ready".
  - RELEASE advances only when count = GAP_CYCLES-1 AND `stage_ack_i[index]` = 1. The counter saturates at GAP_CYCLES-1 while waiting.
  - Ack input is used directly; the stages share `clk`.
- Undefined: the port is absent and sequencing is purely timed.

Decomposition:
- Package `reset_seq_pkg`:
  - `state_t` enum {HOLD, RELEASE, RUN}.
  - Width helper function for the counter.
  - Default parameter constants.
- Sub-module `reset_sync`:
  - Parameter DEPTH; ports clk, reset, rst_sync_o.
  - Async-assert / sync-deassert chain, reusable by other blocks.

Test Plan:
- Power-on (NUM_STAGES=3, SYNC_DEPTH=2, HOLD=4, GAP=2): deassert `reset` -> `stage_rst_o` bits 0/1/2 fall on edges 6/8/10; `done_o` rises on edge 12; `busy_o` falls on edge 12.
- Async reset mid-RELEASE (assert between edges 8 and 9) -> `stage_rst_o` = 3'b111 and `done_o` = 0 with no clock edge. After deassert, full timing repeats from edge 1.
- SW request pulse in RUN at edge T -> `stage_rst_o` = 3'b111 after T; stage 0 releases at T+4, stage 1 at T+6, stage 2 at T+8; `done_o` at T+10.
- SW request pulsed during HOLD and RELEASE -> ignored; timing is identical to the power-on case.
- Every cycle: assert `stage_rst_o` is a thermometer code and `done_o` == !`busy_o`.
- ACK_EN defined, `stage_ack_i[1]` delayed 5 cycles past the gap -> stage 2 release and `done_o` both shift 5 cycles later; the counter stays at 1.
